keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Scanning receiver for a 4x4 hex matrix keypad, the input counterpart of the multiplexed seven-segment display path.
- Drives one keypad column low at a time, advancing on the shared `refresh` strobe, and samples the four row lines.
- Debounces presses and releases, then reports the 4-bit hex key code with a one-cycle `key_valid` pulse and a `key_held` level.
- Sits beside the display driver in the clock design and feeds the time-set logic.

Parameters:
- DEB_TICKS, 4, number of consecutive identical refresh samples required to accept a press and to accept a release (range 2..15).

Ports:
- ck  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- refresh  input  1  one-cycle scan strobe; pulses are at least 4 ck cycles apart.
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to ck.
- col  output  4  keypad column drive, active-low one-hot, registered.
- key  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high from acceptance until the release is accepted.

Behaviour:
- Interface: one clock; reset is synchronous and active-low; clock port is ck, reset port is rst_n.
- Reset (rst_n=0 at a ck edge) is honoured in any state, including mid-debounce or while held. It gives:
  - col=4'b1110 (column 0 driven), key=0, key_valid=0, key_held=0.
  - state=SCAN, column index 0, debounce counter 0, synchroniser flops 4'b1111.
  - `refresh` is ignored during reset.
- row passes through a 2-flop synchroniser (rs). All decisions use rs, and only on cycles with refresh=1 (a "sample").
- A valid pattern is rs with exactly one bit 0; its row index r is the position of that 0. 4'b1111 is idle. Any pattern with two or more 0s is invalid and is treated as idle.
- State SCAN:
  - Valid pattern on a sample: latch r and the current column index c, counter=1, go to DEBOUNCE. The column is frozen (col unchanged).
  - Otherwise: advance c = c+1 mod 4, giving col sequence 1110→1101→1011→0111→1110.
- State DEBOUNCE (column frozen):
  - Sample equals the latched pattern: counter++.
  - When the counter reaches DEB_TICKS, on the next ck:
    - key = map(r,c), key_valid=1 for exactly one cycle, key_held=1.
    - Go to HELD.
  - Any other sample: go to SCAN and advance the column on that sample. No key_valid.
- State HELD (column frozen, key_held=1):
  - Sample rs=4'b1111: counter=1, go to RELEASE.
  - Any other sample (including a different or multiple key): stay in HELD.
- State RELEASE (column frozen, key_held=1):
  - Sample 4'b1111: counter++. When it reaches DEB_TICKS: key_held=0, go to SCAN, and advance the column on that same sample.
  - Any non-idle sample: return to HELD. No new key_valid.
- Key map map(r,c):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
  - c=0 is the leftmost entry.
- Retention:
  - key holds its value until the next acceptance; it is not cleared on release.
  - key_valid is never asserted in two consecutive cycles.
- Latency:
  - Press whose first valid sample is refresh k: key_valid is high the cycle after refresh k+DEB_TICKS-1.
  - Release whose first idle sample is refresh m: key_held falls the cycle after refresh m+DEB_TICKS-1.
- Simultaneous events: reset overrides refresh.

Test Plan:
- Reset, then release rst_n with no key: col=1110, key=0, key_valid=0, key_held=0. Five refresh pulses give col 1101,1011,0111,1110,1101.
- Hold key '5' (row[1]=0 whenever col=1101, through the 2-cycle sync), DEB_TICKS=4:
  - Exactly one key_valid pulse, the cycle after the 4th matching sample; key=4'h5, key_held=1.
  - col stays 1101 for 20 further refreshes.
- Bounce on key 'C' (row2, col3): low for 2 samples, then high → no key_valid, key unchanged, scanning resumes from col 0111 to 1110.
- Release from HELD on 'D' (row3, col3):
  - Rows idle for 2 samples, then low again → key_held stays 1 and no second key_valid.
  - Then idle for 4 samples → key_held=0 after the 4th, scanning resumes.
- Rows 0 and 2 both low on col 0 → no DEBOUNCE entry, no key_valid, column keeps advancing.
- Reset mid-DEBOUNCE and mid-HELD: the cycle after the rst_n=0 edge all outputs are at their reset values and col=1110. After rst_n=1 with the key still pressed, a fresh debounce is required before key_valid.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: walks an active-low column strobe on each refresh,
// debounces row presses/releases and reports the accepted key code.
module keypad_scan #(
  parameter int DEB_TICKS = 4
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       refresh,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] DEB = 4'(DEB_TICKS);

  state_t     state, state_nx;
  logic [3:0] rs_meta, rs;
  logic [1:0] col_idx, col_idx_nx;
  logic [1:0] r_lat, r_lat_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] key_nx;
  logic       key_valid_nx, key_held_nx;

  logic [3:0] low;
  logic       one_low;
  logic [1:0] r_idx;
  logic [3:0] cnt_inc;
  logic       cnt_done;
  logic       rs_idle;
  logic       rs_match;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // A pattern is a valid key only when exactly one row line is pulled low.
  assign low      = ~rs;
  assign one_low  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign rs_idle  = (rs == 4'b1111);
  assign rs_match = (rs == ~(4'b0001 << r_lat));
  assign cnt_inc  = cnt + 4'd1;
  assign cnt_done = (cnt_inc == DEB);

  always_comb begin
    r_idx = 2'd0;
    case (low)
      4'b0010: r_idx = 2'd1;
      4'b0100: r_idx = 2'd2;
      4'b1000: r_idx = 2'd3;
      default: r_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_nx     = state;
    col_idx_nx   = col_idx;
    r_lat_nx     = r_lat;
    cnt_nx       = cnt;
    key_nx       = key;
    key_valid_nx = 1'b0;
    key_held_nx  = key_held;
    if (refresh) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            r_lat_nx = r_idx;
            cnt_nx   = 4'd1;
            state_nx = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rs_match) begin
            if (cnt_done) begin
              key_nx       = key_map(r_lat, col_idx);
              key_valid_nx = 1'b1;
              key_held_nx  = 1'b1;
              cnt_nx       = 4'd0;
              state_nx     = HELD;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx     = 4'd0;
            col_idx_nx = col_idx + 2'd1;
            state_nx   = SCAN;
          end
        end
        HELD: begin
          if (rs_idle) begin
            cnt_nx   = 4'd1;
            state_nx = RELEASE;
          end
        end
        default: begin
          // RELEASE: any activity on the rows drops back to HELD without a new key.
          if (rs_idle) begin
            if (cnt_done) begin
              key_held_nx = 1'b0;
              cnt_nx      = 4'd0;
              col_idx_nx  = col_idx + 2'd1;
              state_nx    = SCAN;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx   = 4'd0;
            state_nx = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      rs_meta   <= 4'b1111;
      rs        <= 4'b1111;
      state     <= SCAN;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      r_lat     <= 2'd0;
      cnt       <= 4'd0;
      key       <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      rs_meta   <= row;
      rs        <= rs_meta;
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      col       <= ~(4'b0001 << col_idx_nx);
      r_lat     <= r_lat_nx;
      cnt       <= cnt_nx;
      key       <= key_nx;
      key_valid <= key_valid_nx;
      key_held  <= key_held_nx;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a modelled keypad drives row from col and
// each step is checked with an immediate assertion.
module tb_keypad_scan;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       refresh;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  int kv_consec = 0;
  logic kv_prev = 1'b0;

  logic       press_en = 1'b0;
  logic [1:0] press_r = 2'd0;
  logic [1:0] press_c = 2'd0;
  logic       multi_en = 1'b0;

  localparam logic [1:0] S_SCAN = 2'd0, S_DEB = 2'd1, S_HELD = 2'd2, S_REL = 2'd3;

  keypad_scan #(.DEB_TICKS(4)) dut (
    .ck(ck), .rst_n(rst_n), .refresh(refresh), .row(row), .col(col),
    .key(key), .key_valid(key_valid), .key_held(key_held), .state_dbg(state_dbg)
  );

  always #5 ck = ~ck;

  // Keypad model: a pressed switch shorts its row to the driven column.
  always_comb begin
    row = 4'b1111;
    if (press_en && !col[press_c]) row[press_r] = 1'b0;
    if (multi_en && !col[0]) begin
      row[0] = 1'b0;
      row[2] = 1'b0;
    end
  end

  always @(negedge ck) begin
    if (key_valid) kv_count++;
    if (key_valid && kv_prev) kv_consec++;
    kv_prev = key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  // Gap of four idle cycles, then a one-cycle refresh; returns just after its edge.
  task automatic pulse();
    step(4);
    refresh = 1'b1;
    step(1);
    refresh = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, 8'(col), 8'h0E);
    chk({tag, "_key"}, 8'(key), 8'h00);
    chk({tag, "_kv"}, 8'(key_valid), 8'h00);
    chk({tag, "_kh"}, 8'(key_held), 8'h00);
    chk({tag, "_st"}, 8'(state_dbg), 8'(S_SCAN));
  endtask

  logic [3:0] exp_cols [5];

  initial begin
    exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    rst_n   = 1'b0;
    refresh = 1'b0;
    step(3);
    chk_reset("rst");
    rst_n = 1'b1;
    step(1);
    chk_reset("rst_rel");

    for (int i = 0; i < 5; i++) begin
      pulse();
      chk($sformatf("scan_col%0d", i), 8'(col), 8'(exp_cols[i]));
    end

    // Key 5 (row1, col1) held while col=1101.
    press_r = 2'd1; press_c = 2'd1; press_en = 1'b1;
    pulse();
    chk("k5_s1_st", 8'(state_dbg), 8'(S_DEB));
    chk("k5_s1_col", 8'(col), 8'h0D);
    pulse();
    chk("k5_s2_kv", 8'(key_valid), 8'h00);
    pulse();
    chk("k5_s3_kv", 8'(key_valid), 8'h00);
    chk("k5_s3_kh", 8'(key_held), 8'h00);
    pulse();
    chk("k5_s4_kv", 8'(key_valid), 8'h01);
    chk("k5_s4_key", 8'(key), 8'h05);
    chk("k5_s4_kh", 8'(key_held), 8'h01);
    step(1);
    chk("k5_kv_drop", 8'(key_valid), 8'h00);
    for (int i = 0; i < 20; i++) begin
      pulse();
      chk($sformatf("k5_hold_col%0d", i), 8'(col), 8'h0D);
    end
    chk("k5_hold_kh", 8'(key_held), 8'h01);
    chk("k5_hold_cnt", 8'(kv_count), 8'd1);

    press_en = 1'b0;
    pulse();
    chk("k5_rel1_st", 8'(state_dbg), 8'(S_REL));
    pulse();
    pulse();
    chk("k5_rel3_kh", 8'(key_held), 8'h01);
    pulse();
    chk("k5_rel4_kh", 8'(key_held), 8'h00);
    chk("k5_rel4_col", 8'(col), 8'h0B);
    chk("k5_rel4_key", 8'(key), 8'h05);

    // Bounce on C (row2, col3): two matching samples then gone.
    press_r = 2'd2; press_c = 2'd3; press_en = 1'b1;
    pulse();
    chk("c_col", 8'(col), 8'h07);
    pulse();
    chk("c_deb_st", 8'(state_dbg), 8'(S_DEB));
    pulse();
    press_en = 1'b0;
    pulse();
    chk("c_bounce_st", 8'(state_dbg), 8'(S_SCAN));
    chk("c_bounce_col", 8'(col), 8'h0E);
    chk("c_bounce_key", 8'(key), 8'h05);
    chk("c_bounce_cnt", 8'(kv_count), 8'd1);

    // Key D (row3, col3): accept, broken release, then full release.
    press_r = 2'd3; press_c = 2'd3; press_en = 1'b1;
    repeat (3) pulse();
    chk("d_col", 8'(col), 8'h07);
    repeat (3) pulse();
    chk("d_s3_kv", 8'(key_valid), 8'h00);
    pulse();
    chk("d_kv", 8'(key_valid), 8'h01);
    chk("d_key", 8'(key), 8'h0D);
    press_en = 1'b0;
    pulse();
    pulse();
    chk("d_rel_st", 8'(state_dbg), 8'(S_REL));
    press_en = 1'b1;
    pulse();
    chk("d_back_st", 8'(state_dbg), 8'(S_HELD));
    chk("d_back_kh", 8'(key_held), 8'h01);
    press_en = 1'b0;
    repeat (3) pulse();
    chk("d_rel3_kh", 8'(key_held), 8'h01);
    pulse();
    chk("d_rel4_kh", 8'(key_held), 8'h00);
    chk("d_rel4_col", 8'(col), 8'h0E);
    chk("d_cnt", 8'(kv_count), 8'd2);

    // Rows 0 and 2 both low on col 0: invalid, keep scanning.
    multi_en = 1'b1;
    pulse();
    chk("multi_st", 8'(state_dbg), 8'(S_SCAN));
    chk("multi_col", 8'(col), 8'h0D);
    multi_en = 1'b0;
    pulse();
    chk("multi_col2", 8'(col), 8'h0B);
    chk("multi_cnt", 8'(kv_count), 8'd2);

    // Reset in the middle of a debounce, with refresh asserted alongside.
    press_r = 2'd1; press_c = 2'd1; press_en = 1'b1;
    repeat (4) pulse();
    chk("rdeb_pre_st", 8'(state_dbg), 8'(S_DEB));
    pulse();
    rst_n = 1'b0;
    refresh = 1'b1;
    step(1);
    refresh = 1'b0;
    chk_reset("rdeb");
    rst_n = 1'b1;
    pulse();
    chk("rdeb_s1_col", 8'(col), 8'h0D);
    repeat (3) pulse();
    chk("rdeb_s4_kv", 8'(key_valid), 8'h00);
    pulse();
    chk("rdeb_s5_kv", 8'(key_valid), 8'h01);
    chk("rdeb_s5_key", 8'(key), 8'h05);

    // Reset while held; the still-pressed key must be debounced afresh.
    pulse();
    chk("rheld_pre_st", 8'(state_dbg), 8'(S_HELD));
    rst_n = 1'b0;
    step(1);
    chk_reset("rheld");
    rst_n = 1'b1;
    repeat (4) pulse();
    chk("rheld_s4_kv", 8'(key_valid), 8'h00);
    pulse();
    chk("rheld_s5_kv", 8'(key_valid), 8'h01);
    chk("rheld_s5_key", 8'(key), 8'h05);
    chk("rheld_s5_kh", 8'(key_held), 8'h01);
    step(2);

    chk("kv_total", 8'(kv_count), 8'd4);
    chk("kv_consec", 8'(kv_consec), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
